// File: rtl/apb_master_pkg.sv
// Shared types and constants for the APB initiator that drives the USRT slave port.
package apb_master_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } state_e;

  localparam logic [31:0] USRT_ADDR_TX = 32'h0;
  localparam logic [31:0] USRT_ADDR_RX = 32'h4;
  localparam logic [31:0] USRT_ADDR_ST = 32'h8;

  // Command record layout: {write, addr, wdata}
  function automatic int cmd_w(input int addr_w);
    return 1 + addr_w + 8;
  endfunction

endpackage

// File: rtl/apb_master_cmd_fifo.sv
// Small synchronous command FIFO; a push into a full FIFO is accepted when a pop happens in the same cycle.
module apb_cmd_fifo #(
  parameter int WIDTH = 41,
  parameter int DEPTH = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [AW:0]      cnt_q;
  logic             do_push, do_pop;

  assign empty_o = (cnt_q == '0);
  assign full_o  = (cnt_q == FULL_CNT);
  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & (~full_o | do_pop);
  assign rdata_o = mem_q[rd_ptr_q];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      cnt_q <= cnt_q + {{AW{1'b0}}, do_push} - {{AW{1'b0}}, do_pop};
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule

// File: rtl/apb_master.sv
// APB initiator: one command in, one SETUP/ACCESS transfer with bounded wait, one response out.
// Optional 4-entry command buffer enabled by APB_MASTER_CMD_FIFO_EN.
//   IDLE   | no transfer, waiting for a command
//   SETUP  | Psel high, Penable low, address/data presented
//   ACCESS | Psel and Penable high, waiting for Pready or timeout
module apb_master #(
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int ADDR_W         = 32
) (
  input  logic              i_Pclk,
  input  logic              i_Rst,
  input  logic              i_Cmd_Valid,
  output logic              o_Cmd_Ready,
  input  logic              i_Cmd_Write,
  input  logic [ADDR_W-1:0] i_Cmd_Addr,
  input  logic [7:0]        i_Cmd_Wdata,
  output logic              o_Rsp_Valid,
  output logic [7:0]        o_Rsp_Rdata,
  output logic              o_Rsp_Timeout,
  output logic [ADDR_W-1:0] o_Paddr,
  output logic              o_Psel,
  output logic              o_Penable,
  output logic              o_Pwrite,
  output logic [7:0]        o_Pwdata,
  input  logic              i_Pready,
  input  logic [7:0]        i_Prdata
);
  import apb_master_pkg::*;

  localparam int          CMD_W   = cmd_w(ADDR_W);
  localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYCLES - 1);

  state_e            state_q, state_d;
  logic [15:0]       cnt_q, cnt_d;
  logic [ADDR_W-1:0] paddr_q, paddr_d;
  logic              pwrite_q, pwrite_d;
  logic [7:0]        pwdata_q, pwdata_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic              rsp_timeout_q, rsp_timeout_d;
  logic [7:0]        rsp_rdata_q, rsp_rdata_d;

  logic              cmd_avail, cmd_take;
  logic [CMD_W-1:0]  cmd_rec;

  assign cmd_take = (state_q == IDLE) & cmd_avail;

`ifdef APB_MASTER_CMD_FIFO_EN
  logic fifo_full, fifo_empty;

  apb_cmd_fifo #(.WIDTH(CMD_W), .DEPTH(4)) u_cmd_fifo (
    .clk_i   (i_Pclk),
    .rst_i   (i_Rst),
    .push_i  (i_Cmd_Valid & ~fifo_full),
    .wdata_i ({i_Cmd_Write, i_Cmd_Addr, i_Cmd_Wdata}),
    .pop_i   (cmd_take),
    .rdata_o (cmd_rec),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign o_Cmd_Ready = ~fifo_full;
  assign cmd_avail   = ~fifo_empty;
`else
  assign o_Cmd_Ready = (state_q == IDLE);
  assign cmd_avail   = i_Cmd_Valid;
  assign cmd_rec     = {i_Cmd_Write, i_Cmd_Addr, i_Cmd_Wdata};
`endif

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    paddr_d       = paddr_q;
    pwrite_d      = pwrite_q;
    pwdata_d      = pwdata_q;
    rsp_valid_d   = 1'b0;
    rsp_timeout_d = 1'b0;
    rsp_rdata_d   = rsp_rdata_q;
    case (state_q)
      IDLE: begin
        if (cmd_take) begin
          state_d  = SETUP;
          pwrite_d = cmd_rec[CMD_W-1];
          paddr_d  = cmd_rec[8 +: ADDR_W];
          pwdata_d = cmd_rec[CMD_W-1] ? cmd_rec[7:0] : 8'h00;
        end
      end
      SETUP: begin
        state_d = ACCESS;
        cnt_d   = '0;
      end
      ACCESS: begin
        // Pready takes priority over a timeout landing in the same cycle
        if (i_Pready) begin
          state_d     = IDLE;
          rsp_valid_d = 1'b1;
          rsp_rdata_d = pwrite_q ? 8'h00 : i_Prdata;
        end else if (cnt_q == TO_LAST) begin
          state_d       = IDLE;
          rsp_valid_d   = 1'b1;
          rsp_timeout_d = 1'b1;
          rsp_rdata_d   = 8'h00;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_Pclk) begin
    if (i_Rst) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      paddr_q       <= '0;
      pwrite_q      <= 1'b0;
      pwdata_q      <= '0;
      rsp_valid_q   <= 1'b0;
      rsp_timeout_q <= 1'b0;
      rsp_rdata_q   <= '0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      paddr_q       <= paddr_d;
      pwrite_q      <= pwrite_d;
      pwdata_q      <= pwdata_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_timeout_q <= rsp_timeout_d;
      rsp_rdata_q   <= rsp_rdata_d;
    end
  end

  assign o_Psel        = (state_q == SETUP) | (state_q == ACCESS);
  assign o_Penable     = (state_q == ACCESS);
  assign o_Paddr       = paddr_q;
  assign o_Pwrite      = pwrite_q;
  assign o_Pwdata      = pwdata_q;
  assign o_Rsp_Valid   = rsp_valid_q;
  assign o_Rsp_Timeout = rsp_timeout_q;
  assign o_Rsp_Rdata   = rsp_rdata_q;

endmodule

// File: tb/tb_apb_master.sv
// Self-checking bench for apb_master: directed protocol cases plus randomized transfers against a transaction-level model.
module tb_apb_master;
  import apb_master_pkg::*;

  localparam int TO = 8;
`ifdef APB_MASTER_CMD_FIFO_EN
  localparam bit FIFO = 1'b1;
`else
  localparam bit FIFO = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [31:0] cmd_addr;
  logic [7:0]  cmd_wdata;
  logic        rsp_valid, rsp_timeout;
  logic [7:0]  rsp_rdata;
  logic [31:0] paddr;
  logic        psel, penable, pwrite;
  logic [7:0]  pwdata;
  logic        pready;
  logic [7:0]  prdata;

  int checks   = 0;
  int failures = 0;

  apb_master #(.TIMEOUT_CYCLES(TO), .ADDR_W(32)) dut (
    .i_Pclk        (clk),
    .i_Rst         (rst),
    .i_Cmd_Valid   (cmd_valid),
    .o_Cmd_Ready   (cmd_ready),
    .i_Cmd_Write   (cmd_write),
    .i_Cmd_Addr    (cmd_addr),
    .i_Cmd_Wdata   (cmd_wdata),
    .o_Rsp_Valid   (rsp_valid),
    .o_Rsp_Rdata   (rsp_rdata),
    .o_Rsp_Timeout (rsp_timeout),
    .o_Paddr       (paddr),
    .o_Psel        (psel),
    .o_Penable     (penable),
    .o_Pwrite      (pwrite),
    .o_Pwdata      (pwdata),
    .i_Pready      (pready),
    .i_Prdata      (prdata)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // One transfer; slave raises Pready on ACCESS cycle number waits+1 (never if waits >= TO).
  task automatic xfer(input bit wr, input logic [31:0] addr, input logic [7:0] wd, input int waits);
    logic [7:0] rd;
    logic [7:0] exp_wd;
    bit         exp_to;
    rd     = 8'($urandom);
    exp_wd = wr ? wd : 8'h00;
    exp_to = (waits >= TO);
    chk("idle_ready", cmd_ready, 1);
    cmd_valid = 1'b1;
    cmd_write = wr;
    cmd_addr  = addr;
    cmd_wdata = wd;
    pready    = 1'($urandom);
    tick;
    cmd_valid = 1'b0;
    cmd_addr  = $urandom;
    cmd_wdata = 8'($urandom);
    if (FIFO) tick;
    chk("setup_psel", psel, 1);
    chk("setup_penable", penable, 0);
    chk("setup_paddr", paddr, addr);
    chk("setup_pwrite", pwrite, wr);
    chk("setup_pwdata", pwdata, exp_wd);
    chk("setup_ready", cmd_ready, FIFO ? 1 : 0);
    pready = 1'($urandom);
    tick;
    pready = 1'b0;
    for (int k = 0; k < TO; k++) begin
      chk("acc_psel", psel, 1);
      chk("acc_penable", penable, 1);
      chk("acc_paddr", paddr, addr);
      chk("acc_pwrite", pwrite, wr);
      chk("acc_pwdata", pwdata, exp_wd);
      chk("acc_no_rsp", rsp_valid, 0);
      pready = (k == waits);
      prdata = pready ? rd : 8'($urandom);
      tick;
      if (k == waits) break;
    end
    pready = 1'b0;
    chk("rsp_valid", rsp_valid, 1);
    chk("rsp_timeout", rsp_timeout, exp_to);
    chk("rsp_rdata", rsp_rdata, (exp_to || wr) ? 8'h00 : rd);
    chk("rsp_psel_low", psel, 0);
    chk("rsp_penable_low", penable, 0);
    chk("rsp_ready", cmd_ready, 1);
    chk("rsp_paddr_hold", paddr, addr);
    tick;
    chk("rsp_pulse", rsp_valid, 0);
    chk("rdata_hold", rsp_rdata, (exp_to || wr) ? 8'h00 : rd);
  endtask

  task automatic back_to_back;
    logic [31:0] addrs [3];
    int          acc [3];
    int          idx, seen;
    bit          hs;
    addrs[0] = USRT_ADDR_TX;
    addrs[1] = USRT_ADDR_RX;
    addrs[2] = USRT_ADDR_ST;
    idx  = 0;
    seen = 0;
    cmd_valid = 1'b1;
    cmd_write = 1'b0;
    cmd_addr  = addrs[0];
    cmd_wdata = 8'h00;
    for (int cyc = 0; cyc < 40 && seen < 3; cyc++) begin
      if (rsp_valid) begin
        chk("b2b_rdata", rsp_rdata, addrs[seen][7:0] ^ 8'h5A);
        chk("b2b_timeout", rsp_timeout, 0);
        seen++;
      end
      hs = cmd_valid & cmd_ready;
      if (hs) begin
        acc[idx] = cyc;
        idx++;
      end
      pready = psel & penable;
      prdata = paddr[7:0] ^ 8'h5A;
      tick;
      if (hs) begin
        if (idx < 3) cmd_addr = addrs[idx];
        else cmd_valid = 1'b0;
      end
    end
    pready    = 1'b0;
    cmd_valid = 1'b0;
    chk("b2b_rsp_count", seen, 3);
    chk("b2b_accepts", idx, 3);
    chk("b2b_gap1", acc[1] - acc[0], FIFO ? 1 : 3);
    chk("b2b_gap2", acc[2] - acc[1], FIFO ? 1 : 3);
  endtask

  task automatic reset_in_access;
    cmd_valid = 1'b1;
    cmd_write = 1'b0;
    cmd_addr  = USRT_ADDR_RX;
    cmd_wdata = 8'h00;
    pready    = 1'b0;
    tick;
    cmd_valid = 1'b0;
    if (FIFO) tick;
    tick;
    tick;
    chk("rst_pre_penable", penable, 1);
    rst = 1'b1;
    tick;
    chk("rst_psel", psel, 0);
    chk("rst_penable", penable, 0);
    chk("rst_no_rsp", rsp_valid, 0);
    chk("rst_rdata", rsp_rdata, 0);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick;
      chk("post_rst_ready", cmd_ready, 1);
      chk("post_rst_psel", psel, 0);
      chk("post_rst_no_rsp", rsp_valid, 0);
    end
  endtask

  initial begin
    rst       = 1'b1;
    cmd_valid = 1'b0;
    cmd_write = 1'b0;
    cmd_addr  = '0;
    cmd_wdata = '0;
    pready    = 1'b0;
    prdata    = '0;
    tick;
    tick;
    chk("reset_psel", psel, 0);
    chk("reset_penable", penable, 0);
    chk("reset_pwrite", pwrite, 0);
    chk("reset_rsp_valid", rsp_valid, 0);
    chk("reset_rsp_timeout", rsp_timeout, 0);
    chk("reset_paddr", paddr, 0);
    chk("reset_pwdata", pwdata, 0);
    chk("reset_rdata", rsp_rdata, 0);
    chk("reset_ready", cmd_ready, 1);
    rst = 1'b0;
    tick;

    xfer(1'b1, USRT_ADDR_TX, 8'hA5, 0);
    xfer(1'b0, USRT_ADDR_RX, 8'h77, 5);
    xfer(1'b0, USRT_ADDR_ST, 8'h00, 1000);
    xfer(1'b1, USRT_ADDR_TX, 8'h5C, TO - 1);
    xfer(1'b0, USRT_ADDR_RX, 8'h00, TO - 1);
    xfer(1'b1, USRT_ADDR_TX, 8'h3E, TO);
    back_to_back();
    reset_in_access();

    for (int n = 0; n < 24; n++) begin
      logic [31:0] a;
      case ($urandom_range(0, 3))
        0: a = USRT_ADDR_TX;
        1: a = USRT_ADDR_RX;
        2: a = USRT_ADDR_ST;
        default: a = $urandom;
      endcase
      xfer(1'($urandom), a, 8'($urandom), int'($urandom_range(0, TO + 3)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
